// File: rtl/layer1_pkg.sv
// layer1_pkg: shared sizes, FSM states and latency constants for the layer-1 column sequencer.
package layer1_pkg;
  localparam int NLANE = 10;
  localparam int W = 16;
  localparam int AW = 8;
  localparam int MAC_LAT = 2;
  // start-to-res_valid latency is num_taps + MAC_LAT + LAT_OFS
  localparam int LAT_OFS = 4;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, HOLD} state_e;
endpackage

// File: rtl/layer1_seq.sv
// layer1_seq: sequences weight/pixel reads into a layer-1 MAC column and returns the column over valid/ready.
module layer1_seq #(
  parameter int NLANE = layer1_pkg::NLANE,
  parameter int W = layer1_pkg::W,
  parameter int AW = layer1_pkg::AW,
  parameter int MAC_LAT = layer1_pkg::MAC_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [AW-1:0]      base_addr_i,
  input  logic [7:0]         num_taps_i,
  output logic               busy_o,
  output logic               w_rd_o,
  output logic [AW-1:0]      w_addr_o,
  input  logic [W-1:0]       w_data_i,
  output logic               p_rd_o,
  output logic [AW-1:0]      p_addr_o,
  input  logic [NLANE*W-1:0] p_data_i,
  output logic               mac_clr_o,
  output logic [W-1:0]       mac_weight_o,
  output logic [NLANE*W-1:0] mac_pixels_o,
  input  logic [NLANE*W-1:0] mac_column_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [NLANE*W-1:0] res_data_o,
  output logic               done_o
);
  import layer1_pkg::*;
  // drain covers the read latency, the array's weight register and MAC_LAT
  localparam logic [7:0] DRAIN_LAST = 8'(MAC_LAT + LAT_OFS - 3);
  state_e state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [7:0] num_q, num_d, cnt_q, cnt_d;
  logic rd_q, run, capture;
  logic [NLANE*W-1:0] pix_q, res_q;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    num_d = num_q;
    cnt_d = cnt_q + 8'd1;
    case (state_q)
      IDLE: if (start_i && num_taps_i != 8'd0) begin
        state_d = CLEAR;
        base_d = base_addr_i;
        num_d = num_taps_i;
      end
      CLEAR: begin
        state_d = RUN;
        cnt_d = '0;
      end
      RUN: if (cnt_q == num_q - 8'd1) begin
        state_d = DRAIN;
        cnt_d = '0;
      end
      DRAIN: state_d = (cnt_q == DRAIN_LAST) ? HOLD : DRAIN;
      HOLD: state_d = res_ready_i ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  assign run = state_q == RUN;
  assign capture = state_q == DRAIN && cnt_q == DRAIN_LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q <= '0;
      num_q <= '0;
      cnt_q <= '0;
      rd_q <= 1'b0;
      pix_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      num_q <= num_d;
      cnt_q <= cnt_d;
      rd_q <= run;
      pix_q <= rd_q ? p_data_i : '0;
      res_q <= capture ? mac_column_i : res_q;
    end
  end
  assign busy_o = state_q != IDLE;
  assign w_rd_o = run;
  assign p_rd_o = run;
  assign w_addr_o = run ? base_q + AW'(cnt_q) : '0;
  assign p_addr_o = w_addr_o;
  assign mac_clr_o = state_q == IDLE || state_q == CLEAR;
  assign mac_weight_o = w_data_i;
  assign mac_pixels_o = pix_q;
  assign res_valid_o = state_q == HOLD;
  assign res_data_o = res_q;
  assign done_o = res_valid_o && res_ready_i;
endmodule

// File: tb/tb_layer1_seq.sv
// tb_layer1_seq: directed vector bench with memory and MAC column models around layer1_seq.
module tb_layer1_seq;
  localparam int NL = 10;
  localparam int W = 16;
  localparam int AW = 8;
  logic clk = 0, rst_n = 0, start = 0, res_ready = 1;
  logic [AW-1:0] base_addr = '0;
  logic [7:0] num_taps = '0;
  logic busy, w_rd, p_rd, mac_clr, res_valid, done;
  logic [AW-1:0] w_addr, p_addr;
  logic [W-1:0] w_data = '0, mac_weight;
  logic [NL*W-1:0] p_data = '0, mac_pixels, mac_column, res_data;
  int checks = 0, errors = 0, done_cnt = 0, rd_mis = 0;
  logic [AW-1:0] addrq[$];

  always #5 clk = ~clk;

  layer1_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base_addr), .num_taps_i(num_taps),
    .busy_o(busy), .w_rd_o(w_rd), .w_addr_o(w_addr), .w_data_i(w_data),
    .p_rd_o(p_rd), .p_addr_o(p_addr), .p_data_i(p_data), .mac_clr_o(mac_clr),
    .mac_weight_o(mac_weight), .mac_pixels_o(mac_pixels), .mac_column_i(mac_column),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .done_o(done)
  );

  // memories answer one cycle after the strobe; junk when not read
  logic [W-1:0] wmem[256];
  logic [NL*W-1:0] pmem[256];
  always @(posedge clk) begin
    w_data <= w_rd ? wmem[w_addr] : 16'hdead;
    p_data <= p_rd ? pmem[p_addr] : '1;
  end

  // column array: weight register, 16-bit accumulate, one output register
  logic [W-1:0] wreg = '0;
  logic [W-1:0] acc[NL];
  logic [NL*W-1:0] col = '0;
  always @(posedge clk) begin
    wreg <= mac_weight;
    for (int i = 0; i < NL; i++) begin
      acc[i] <= mac_clr ? 16'd0 : acc[i] + wreg * mac_pixels[i*W +: W];
      col[i*W +: W] <= acc[i];
    end
  end
  assign mac_column = col;

  always @(negedge clk) begin
    if (w_rd) begin
      addrq.push_back(w_addr);
      if (!p_rd || p_addr !== w_addr) rd_mis++;
    end
    if (done) done_cnt++;
  end

  typedef struct {
    logic [7:0] base;
    logic [7:0] n;
    int kind;
    logic [15:0] e0;
    logic [15:0] step;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill(input int kind, input logic [7:0] b, input logic [7:0] n);
    logic [7:0] a;
    for (int k = 0; k < 256; k++) begin
      wmem[k] = 16'h7777;
      pmem[k] = {NL{16'h0303}};
    end
    for (int r = 0; r < int'(n); r++) begin
      a = 8'(int'(b) + r);
      wmem[a] = kind == 0 ? 16'd1 : kind == 1 ? 16'(r + 1) : 16'h4000;
      for (int i = 0; i < NL; i++)
        pmem[a][i*W +: W] = kind == 0 ? 16'd1 : kind == 1 ? 16'(i) : 16'(i + 1);
    end
  endtask

  task automatic launch(input logic [7:0] b, input logic [7:0] n);
    @(posedge clk);
    #1;
    base_addr = b;
    num_taps = n;
    start = 1;
    addrq.delete();
    done_cnt = 0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      start = 0;
      lat++;
    end while (!res_valid && lat < 2000);
  endtask

  task automatic chk_addrs(input logic [7:0] b, input logic [7:0] n);
    int bad;
    bad = 0;
    for (int r = 0; r < addrq.size(); r++)
      if (addrq[r] !== 8'(int'(b) + r)) bad++;
    chk("read count", addrq.size(), 32'(n));
    chk("read addresses", bad, 0);
  endtask

  initial begin
    int lat, bad;
    logic [NL*W-1:0] exp_col;
    vecs[0] = '{8'd0,   8'd9,   0, 16'd9,     16'd0};
    vecs[1] = '{8'h10,  8'd4,   1, 16'd0,     16'd10};
    vecs[2] = '{8'd254, 8'd4,   1, 16'd0,     16'd10};
    vecs[3] = '{8'h40,  8'd5,   2, 16'h4000,  16'h4000};
    vecs[4] = '{8'h80,  8'd1,   0, 16'd1,     16'd0};
    vecs[5] = '{8'd3,   8'd255, 0, 16'd255,   16'd0};
    #2;
    chk("rst busy", busy, 0);
    chk("rst rd", {w_rd, p_rd}, 0);
    chk("rst addr", {w_addr, p_addr}, 0);
    chk("rst pixels", 32'(mac_pixels != '0), 0);
    chk("rst mac_clr", mac_clr, 1);
    chk("rst res_valid", res_valid, 0);
    chk("rst res_data", 32'(res_data != '0), 0);
    chk("rst done", done, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    foreach (vecs[v]) begin
      fill(vecs[v].kind, vecs[v].base, vecs[v].n);
      res_ready = 1;
      launch(vecs[v].base, vecs[v].n);
      wait_valid(lat);
      chk($sformatf("v%0d latency", v), lat, int'(vecs[v].n) + 6);
      chk($sformatf("v%0d done", v), done, 1);
      chk($sformatf("v%0d busy hold", v), busy, 1);
      for (int i = 0; i < NL; i++)
        chk($sformatf("v%0d lane%0d", v, i), res_data[i*W +: W], 16'(vecs[v].e0 + 16'(i) * vecs[v].step));
      chk_addrs(vecs[v].base, vecs[v].n);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid drop", v), res_valid, 0);
      chk($sformatf("v%0d idle", v), busy, 0);
      chk($sformatf("v%0d done count", v), done_cnt, 1);
    end

    // result held back by the consumer; extra starts must be ignored
    fill(1, 8'h20, 8'd4);
    for (int i = 0; i < NL; i++) exp_col[i*W +: W] = 16'(10 * i);
    res_ready = 0;
    launch(8'h20, 8'd4);
    wait_valid(lat);
    chk("hold latency", lat, 10);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (res_valid !== 1 || busy !== 1 || done !== 0 || res_data !== exp_col) bad++;
      start = (k % 3 == 0);
      base_addr = 8'h90;
      num_taps = 8'd3;
      @(posedge clk);
      #1;
    end
    start = 0;
    chk("hold stable", bad, 0);
    chk("hold no reads", addrq.size(), 4);
    res_ready = 1;
    #1;
    chk("hold done", done, 1);
    @(posedge clk);
    #1;
    chk("hold idle", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold done count", done_cnt, 1);
    chk("hold stays idle", busy, 0);

    // reset in the middle of RUN at tap 3
    fill(0, 8'd0, 8'd8);
    launch(8'd0, 8'd8);
    bad = 0;
    do begin
      @(posedge clk);
      #1;
      start = 0;
      bad++;
    end while (!(w_rd && w_addr == 8'd3) && bad < 50);
    chk("reach tap3", w_addr, 3);
    rst_n = 0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst rd", {w_rd, p_rd}, 0);
    chk("arst addr", {w_addr, p_addr}, 0);
    chk("arst pixels", 32'(mac_pixels != '0), 0);
    chk("arst mac_clr", mac_clr, 1);
    chk("arst res", {res_valid, done, 30'(res_data != '0)}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    fill(1, 8'h50, 8'd2);
    launch(8'h50, 8'd2);
    wait_valid(lat);
    chk("post-rst latency", lat, 8);
    for (int i = 0; i < NL; i++)
      chk($sformatf("post-rst lane%0d", i), res_data[i*W +: W], 16'(3 * i));
    @(posedge clk);
    #1;
    chk("post-rst done count", done_cnt, 1);

    // zero-tap start is ignored
    launch(8'h33, 8'd0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      start = 0;
      if (busy !== 0) bad++;
    end
    chk("zero taps busy", bad, 0);
    chk("zero taps reads", addrq.size(), 0);
    chk("rd strobe/addr pairing", rd_mis, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer1_seq.md
LAYER1_SEQ -- requirements
Module: layer1_seq

Interface
REQ-001 Parameter: NLANE, default 10, number of MAC lanes in the layer-1 column array.
REQ-002 Parameter: W, default 16, lane and weight word width in bits.
REQ-003 Parameter: AW, default 8, weight and pixel memory address width.
REQ-004 Parameter: MAC_LAT, default 2, cycles from the last product presented to the lane pixel inputs until the column output is final.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  pulse that requests one column computation.
REQ-008 base_addr  in  AW  first tap address; latched when start is accepted.
REQ-009 num_taps  in  8  taps per column (1..255); latched when start is accepted.
REQ-010 busy  out  1  high from start acceptance until the result handshake completes.
REQ-011 w_rd, w_addr  out  1, AW  weight memory read strobe and address.
REQ-012 w_data  in  W  weight read data, valid exactly one cycle after w_rd.
REQ-013 p_rd, p_addr  out  1, AW  pixel memory read strobe and address.
REQ-014 p_data  in  NLANE*W  pixel read data, valid exactly one cycle after p_rd.
REQ-015 mac_clr  out  1  active-high clear to the column array.
REQ-016 mac_weight  out  W  broadcast weight to the column array, which registers it internally for one cycle.
REQ-017 mac_pixels  out  NLANE*W  lane pixels to the column array; lane i occupies bits [W*i+W-1 : W*i].
REQ-018 mac_column  in  NLANE*W  accumulated lane outputs returned by the column array.
REQ-019 res_valid, res_ready, res_data  out, in, out  1, 1, NLANE*W  result valid/ready handshake with the captured column.
REQ-020 done  out  1  single-cycle pulse on the cycle the result handshake completes.

Function
REQ-021 The FSM SHALL have five states (IDLE, CLEAR, RUN, DRAIN, HOLD), and start SHALL be accepted only in IDLE with num_taps != 0.
  - start with num_taps == 0 is ignored.
  - start in any other state is ignored.
REQ-022 CLEAR SHALL last exactly one cycle, assert mac_clr=1, issue no reads, and reset the tap counter to 0.
REQ-023 RUN SHALL last exactly num_taps cycles; in tap cycle r it SHALL assert w_rd=p_rd=1 with w_addr=p_addr=(base_addr+r) mod 2^AW, so addresses wrap.
REQ-024 mac_weight SHALL be w_data passed through combinationally, and mac_pixels SHALL be p_data delayed one register stage, so each pixel meets its weight after the array's internal weight register.
REQ-025 mac_pixels SHALL be all-zero on every cycle that does not carry a valid tap, because the array accumulates on every clock.
REQ-026 DRAIN SHALL last exactly 2+MAC_LAT cycles.
  - On the last DRAIN cycle, mac_column is registered into res_data.
  - res_valid rises on the following cycle (HOLD).
REQ-027 Latency from the start-accept edge to res_valid=1 SHALL be num_taps+MAC_LAT+4 cycles.
REQ-028 In HOLD, res_valid and res_data SHALL stay stable until the first edge with res_ready=1.
  - On that edge: done=1 for one cycle, res_valid drops, FSM returns to IDLE.
  - res_ready=1 already high when res_valid rises completes the handshake on the first HOLD edge.
REQ-029 mac_clr SHALL also be held at 1 throughout IDLE.
REQ-030 busy SHALL be 1 in CLEAR, RUN, DRAIN and HOLD, and 0 in IDLE.

Reset
REQ-031 Asserting reset SHALL asynchronously force IDLE and drive all outputs to their reset values.
  - Reset values: busy=0, w_rd=p_rd=0, addresses=0, mac_pixels=0, mac_clr=1, res_valid=0, res_data=0, done=0.
REQ-032 Reset asserted mid-operation SHALL abandon the column with no done pulse.
  - After reset deasserts, the next start runs normally from CLEAR.

Structure
REQ-033 NLANE, W, the FSM state enumeration and the latency formula constant SHALL live in a shared package layer1_pkg.
REQ-034 The block SHALL be a single module with no sub-module; the column array is instantiated beside it by the parent.

Verification
REQ-035 All weights=1, all pixels=1, num_taps=9, base_addr=0, res_ready=1: every lane of res_data = 9, res_valid rises 15 cycles after start, and done pulses once.
REQ-036 Tap r has weight r+1 and lane i pixel i, num_taps=4: lane i = 10*i, with the pixel/weight alignment checked against a 16-bit wrapping model.
REQ-037 base_addr=254, num_taps=4: the addresses issued are 254, 255, 0, 1.
REQ-038 res_ready held 0 for 20 cycles: res_data stable, busy=1, start pulses ignored; releasing res_ready gives one done and a return to IDLE.
REQ-039 Reset asserted during RUN of tap 3: outputs take reset values immediately; a following run with num_taps=2 gives the correct result with no residue from the aborted column.
REQ-040 start with num_taps=0: no reads are issued and busy stays 0.
